seq_mul: RTL and testbench
==========================

# seq_mul

Parametrised sequential shift-and-add multiplier with a start/busy/done handshake and early termination on exhausted multiplier bits. It is the successor to the fixed 16-bit repeated-addition multiplier datapath/controller pair. It keeps the controller/datapath split, but multiplies in at most WIDTH+1 iterations instead of b iterations, and adds a registered, held product output. It sits as a slave arithmetic unit beside the other ADLD datapath blocks, driven by a local controller or a testbench.

## Interface
Parameters:
- WIDTH, 16, operand width in bits (≥2); product is 2*WIDTH bits

Ports:
- clk  in  1  single clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  request; sampled only when busy=0
- a  in  WIDTH  multiplicand, sampled on the accepting edge only
- b  in  WIDTH  multiplier, sampled on the accepting edge only
- busy  out  1  high while an operation is in progress (RUN state)
- done  out  1  single-cycle pulse: product holds the new result
- product  out  2*WIDTH  last completed result, held until the next completion

## Operation
- Internal registers: acc (2W), mcand (2W, shifts left), mplr (W, shifts right), state.
- Two internal counters, iter and k, are used only for latency accounting and assertions.
- FSM states: IDLE, RUN, DONE.
- IDLE, or DONE with start=1: on the edge, latch mcand={W'0, a}, mplr=b, acc=0, and go to RUN.
- RUN, each edge:
  - if mplr==0, go to DONE and load product<=acc;
  - else, if mplr[0] then acc<=acc+mcand; then mcand<=mcand<<1, mplr<=mplr>>1.
- DONE: done=1 for exactly one cycle.
  - With start=0, go to IDLE.
  - With start=1, accept the new operands as in IDLE (back-to-back operation).
- Addition is modulo 2^(2W); overflow is impossible for unsigned operands by construction.
- busy=1 only in RUN; done=1 only in DONE; product changes only on the RUN→DONE edge.
- start while in RUN is ignored; no queuing, and operands are not resampled.
- a and b may change freely after the accepting edge.
- Reset (any time, including mid-RUN): state=IDLE, busy=0, done=0, product=0, acc/mcand/mplr=0. The aborted result is discarded.

## Timing
- Let k be the index of the highest set bit of b, plus 1 (k=0 when b=0).
- RUN lasts k+1 cycles.
- done is high in the cycle after edge k+2, counted from the accepting edge (edge 1 = first RUN edge).
- Minimum latency: b=0 gives done 2 cycles after the accepting edge.
- Maximum latency: WIDTH+2 cycles.
- Back-to-back: start held high during DONE gives a new busy in the next cycle, with no IDLE gap.
- Outputs are registered or decoded from state only; there is no combinational path from inputs to outputs.

## Configuration
- SEQ_MUL_SIGNED_EN defined: a and b are two's complement.
  - On accept, latch neg=a[W-1]^b[W-1] and load the magnitudes |a| and |b| as W-bit unsigned values; −2^(W−1) maps to 2^(W−1).
  - On RUN→DONE, product<=neg ? −acc : acc (2W-bit two's complement).
  - k is computed from |b|.
- SEQ_MUL_SIGNED_EN undefined: a and b are unsigned; there is no neg register and no negation logic.

## Structure
- Package seq_mul_pkg contains:
  - the state enum (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - the localparam helpers PW=2*WIDTH and the reset value of product.
- Sub-module seq_mul_ctrl is the FSM only.
  - Inputs: clk, rst_n, start, mplr_zero.
  - Outputs: load, step, capture, busy, done.
- The top level holds the datapath registers, the adder and the optional sign logic.

## Test plan
- WIDTH=16 unsigned: a=13, b=11 → product=143.
  - busy is high for exactly 5 cycles; done pulses once, 6 cycles after the accepting edge.
- b=0, a=0xBEEF → product=0; done 2 cycles after accept.
- a=b=0xFFFF → product=0xFFFE0001; busy high for 17 cycles.
- start pulsed again mid-RUN with different a/b → ignored; first result 7*9=63 is delivered.
  - A new start held during DONE → the second operation begins immediately with no IDLE cycle.
- rst_n low for 1 cycle mid-RUN → busy, done and product are 0 immediately (asynchronous).
  - A following start with 3*4 → product=12.
- SEQ_MUL_SIGNED_EN defined:
  - −3*5 → 0xFFFFFFF1;
  - −32768*−32768 → 0x40000000;
  - 7*−1 → 0xFFFFFFF9.

Source files
------------

// File: rtl/seq_mul_pkg.sv
// seq_mul_pkg: shared FSM encoding and sizing helpers for the seq_mul multiplier.
package seq_mul_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
    localparam int DEF_WIDTH = 16;
    localparam logic PRODUCT_RST = 1'b0;
    function automatic int pw(input int width);
        return 2 * width;
    endfunction
    // Number of significant bits in v (0 for v == 0).
    function automatic int bit_len(input logic [63:0] v);
        int n;
        n = 0;
        for (int i = 0; i < 64; i++) if (v[i]) n = i + 1;
        return n;
    endfunction
endpackage

// File: rtl/seq_mul_ctrl.sv
// seq_mul_ctrl: IDLE/RUN/DONE controller for the shift-and-add multiplier.
module seq_mul_ctrl
    import seq_mul_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    input  logic mplr_zero,
    output logic load,
    output logic step,
    output logic capture,
    output logic busy,
    output logic done
);
    state_t state;
    assign load    = (state != RUN) && start;
    assign step    = (state == RUN) && !mplr_zero;
    assign capture = (state == RUN) && mplr_zero;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= load ? RUN : capture ? DONE : (state == RUN) ? RUN : IDLE;
            busy  <= load || step;
            done  <= capture;
        end
endmodule

// File: rtl/seq_mul.sv
// seq_mul: sequential shift-and-add multiplier with start/busy/done handshake.
// Define SEQ_MUL_SIGNED_EN for two's complement operands.
module seq_mul
    import seq_mul_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);
    localparam int PW = pw(WIDTH);
    localparam int CW = $clog2(WIDTH + 2);
    logic [PW-1:0] acc, mcand, result;
    logic [WIDTH-1:0] mplr, a_mag, b_mag;
    logic [CW-1:0] iter, k;
    logic load, step, capture;
    seq_mul_ctrl u_ctrl (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .mplr_zero(mplr == '0),
        .load(load),
        .step(step),
        .capture(capture),
        .busy(busy),
        .done(done)
    );
`ifdef SEQ_MUL_SIGNED_EN
    logic neg;
    // Most negative value negates to itself, which reads correctly as an unsigned magnitude.
    assign a_mag  = a[WIDTH-1] ? -a : a;
    assign b_mag  = b[WIDTH-1] ? -b : b;
    assign result = neg ? -acc : acc;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) neg <= 1'b0;
        else if (load) neg <= a[WIDTH-1] ^ b[WIDTH-1];
`else
    assign a_mag  = a;
    assign b_mag  = b;
    assign result = acc;
`endif
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            acc     <= '0;
            mcand   <= '0;
            mplr    <= '0;
            iter    <= '0;
            k       <= '0;
            product <= {PW{PRODUCT_RST}};
        end else begin
            if (load) begin
                acc   <= '0;
                mcand <= {{WIDTH{1'b0}}, a_mag};
                mplr  <= b_mag;
                iter  <= '0;
                k     <= CW'(bit_len(64'(b_mag)));
            end else if (step) begin
                if (mplr[0]) acc <= acc + mcand;
                mcand <= mcand << 1;
                mplr  <= mplr >> 1;
                iter  <= iter + 1'b1;
            end
            if (capture) product <= result;
        end
    // Early termination must land exactly after the significant multiplier bits.
    assert property (@(posedge clk) disable iff (!rst_n) capture |-> iter == k);
endmodule

// File: tb/tb_seq_mul.sv
// tb_seq_mul: randomized and directed check of seq_mul against a cycle-level behavioural model.
module tb_seq_mul;
    localparam int W = 16;
    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic [W-1:0] a = '0, b = '0;
    logic busy, done;
    logic [2*W-1:0] product;
    int checks = 0, failures = 0;
    seq_mul #(.WIDTH(W)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .a(a),
        .b(b),
        .busy(busy),
        .done(done),
        .product(product)
    );
    always #5 clk = ~clk;

    function automatic logic [W-1:0] mag(input logic [W-1:0] v);
`ifdef SEQ_MUL_SIGNED_EN
        return v[W-1] ? W'(-v) : v;
`else
        return v;
`endif
    endfunction

    function automatic int klen(input logic [W-1:0] v);
        int n = 0;
        for (int i = 0; i < W; i++) if (v[i]) n = i + 1;
        return n;
    endfunction

    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y);
`ifdef SEQ_MUL_SIGNED_EN
        longint p;
        p = longint'($signed(x)) * longint'($signed(y));
        return p[2*W-1:0];
`else
        logic [63:0] p;
        p = 64'(x) * 64'(y);
        return p[2*W-1:0];
`endif
    endfunction

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
        end
    endtask

    // Model: an accepted operation keeps busy for k+1 cycles, then done for one cycle.
    int mb = 0;
    logic md = 1'b0;
    logic [2*W-1:0] mp = '0, pend = '0;
    always @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            mb = 0;
            md = 1'b0;
            mp = '0;
        end else if (mb > 0) begin
            mb--;
            md = (mb == 0);
            if (mb == 0) mp = pend;
        end else begin
            md = 1'b0;
            if (start) begin
                mb = klen(mag(b)) + 1;
                pend = ref_mul(a, b);
            end
        end

    always @(negedge clk) begin
        chk("busy", 32'(busy), 32'(mb > 0));
        chk("done", 32'(done), 32'(md));
        chk("product", product, mp);
    end

    task automatic accept(input logic [W-1:0] x, input logic [W-1:0] y);
        @(negedge clk);
        start = 1'b1;
        a = x;
        b = y;
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
    endtask

    task automatic wait_done(output int bc, output int lat);
        lat = 1;
        bc = 0;
        while (!done && lat < 64) begin
            bc += int'(busy);
            @(negedge clk);
            lat++;
        end
        chk("done_seen", 32'(done), 32'd1);
    endtask

    task automatic run(input logic [W-1:0] x, input logic [W-1:0] y, output logic [31:0] p,
                       output int bc, output int lat);
        accept(x, y);
        wait_done(bc, lat);
        p = product;
    endtask

    logic [31:0] p;
    int bc, lat;
    logic [W-1:0] t;
    initial begin
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_product", product, 32'd0);
        #2 rst_n = 1'b1;
`ifdef SEQ_MUL_SIGNED_EN
        run(-16'sd3, 16'd5, p, bc, lat);
        chk("m3x5", p, 32'hFFFFFFF1);
        run(16'h8000, 16'h8000, p, bc, lat);
        chk("min_sq", p, 32'h40000000);
        chk("min_sq_busy", 32'(bc), 32'd17);
        run(16'd7, 16'hFFFF, p, bc, lat);
        chk("7xm1", p, 32'hFFFFFFF9);
        chk("7xm1_busy", 32'(bc), 32'd2);
`else
        run(16'd13, 16'd11, p, bc, lat);
        chk("13x11", p, 32'd143);
        chk("13x11_busy", 32'(bc), 32'd5);
        chk("13x11_lat", 32'(lat), 32'd6);
        run(16'hFFFF, 16'hFFFF, p, bc, lat);
        chk("max_sq", p, 32'hFFFE0001);
        chk("max_sq_busy", 32'(bc), 32'd17);
`endif
        run(16'hBEEF, 16'd0, p, bc, lat);
        chk("bzero", p, 32'd0);
        chk("bzero_lat", 32'(lat), 32'd2);
        accept(16'd7, 16'd9);
        @(negedge clk);
        start = 1'b1;
        a = 16'd1;
        b = 16'd2;
        @(negedge clk);
        start = 1'b0;
        wait_done(bc, lat);
        chk("ignore_mid", product, 32'd63);
        start = 1'b1;
        a = 16'd5;
        b = 16'd6;
        @(negedge clk);
        chk("b2b_busy", 32'(busy), 32'd1);
        chk("b2b_done", 32'(done), 32'd0);
        start = 1'b0;
        wait_done(bc, lat);
        chk("b2b_prod", product, 32'd30);
        accept(16'd100, 16'd200);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_done", 32'(done), 32'd0);
        chk("arst_product", product, 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        run(16'd3, 16'd4, p, bc, lat);
        chk("3x4", p, 32'd12);
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            start = ($urandom_range(0, 2) == 0);
            a = W'($urandom);
            t = W'($urandom);
            b = t >> $urandom_range(0, W);
            if ($urandom_range(0, 499) == 0) begin
                #2 rst_n = 1'b0;
                @(negedge clk);
                #2 rst_n = 1'b1;
            end
        end
        start = 1'b0;
        repeat (25) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
